// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: default bus widths, response codes and the
// initiator state encoding.
package axi4lite_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator: one outstanding single-beat read or write, driven from a
// local command port, answered on a local response port, with a latency watchdog.
//
// Handshake rule on every channel (cmd, rsp, AW, W, B, AR, R): a transfer happens
// on the rising edge where VALID and READY are both 1; a VALID, once raised, stays
// up with its payload stable until that edge.
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AXI_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      A_CLK,
    input  logic                      A_RSTn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      AW_VALID,
    input  logic                      AW_READY,
    output logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
    output logic                      W_VALID,
    input  logic                      W_READY,
    output logic [AXI_DATA_WIDTH-1:0] W_DATA,
    input  logic                      B_VALID,
    output logic                      B_READY,
    input  logic [1:0]                B_RESP,
    output logic                      AR_VALID,
    input  logic                      AR_READY,
    output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
    input  logic                      R_VALID,
    output logic                      R_READY,
    input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
    input  logic [1:0]                R_RESP,
    output state_t                    dbg_state
);

    localparam int                WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYCLES);

    state_t                    state_q, state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      write_q, write_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic                      timeout_q, timeout_d;
    logic [WD_W-1:0]           wdog_q, wdog_d;

    logic aw_hs;
    logic w_hs;
    logic wd_late;

    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;

        aw_hs   = (state_q == WR_REQ) && !aw_done_q && AW_READY;
        w_hs    = (state_q == WR_REQ) && !w_done_q && W_READY;
        wd_late = (wdog_q == WD_MAX);

        // Watchdog only observes; it saturates and never aborts the transfer.
        if ((state_q != IDLE) && (state_q != RSP) && !wd_late) begin
            wdog_d = wdog_q + WD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d   = cmd_write;
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wdog_d    = '0;
                    state_d   = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (B_VALID) begin
                    resp_d    = B_RESP;
                    rdata_d   = '0;
                    timeout_d = wd_late;
                    state_d   = RSP;
                end
            end
            RD_REQ: begin
                if (AR_READY) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (R_VALID) begin
                    resp_d    = R_RESP;
                    rdata_d   = R_DATA;
                    timeout_d = wd_late;
                    state_d   = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake controls decode from state only, so reset drops them at once.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        AW_VALID  = (state_q == WR_REQ) && !aw_done_q;
        W_VALID   = (state_q == WR_REQ) && !w_done_q;
        B_READY   = (state_q == WR_RESP);
        AR_VALID  = (state_q == RD_REQ);
        R_READY   = (state_q == RD_RESP);
        rsp_valid = (state_q == RSP);
    end

    assign AW_ADDR     = addr_q;
    assign AR_ADDR     = addr_q;
    assign W_DATA      = wdata_q;
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master: a table of transactions run against a
// latency-programmable slave model, plus reset and idle-side corner sequences.
module tb_axi4lite_master;
    import axi4lite_pkg::*;

    logic        A_CLK;
    logic        A_RSTn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        AW_VALID, AW_READY;
    logic [31:0] AW_ADDR;
    logic        W_VALID, W_READY;
    logic [31:0] W_DATA;
    logic        B_VALID, B_READY;
    logic [1:0]  B_RESP;
    logic        AR_VALID, AR_READY;
    logic [31:0] AR_ADDR;
    logic        R_VALID, R_READY;
    logic [31:0] R_DATA;
    logic [1:0]  R_RESP;
    state_t      dbg_state;

    int n_vec;
    int n_err;

    axi4lite_master #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .A_CLK(A_CLK), .A_RSTn(A_RSTn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        A_CLK = 1'b0;
        forever #5 A_CLK = ~A_CLK;
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_lat;
        int          w_lat;
        int          b_lat;
        int          ar_lat;
        int          r_lat;
        int          rsp_lat;
        logic [1:0]  slv_resp;
        logic [31:0] slv_rdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_to;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic slave_idle();
        AW_READY  = 1'b0;
        W_READY   = 1'b0;
        B_VALID   = 1'b0;
        AR_READY  = 1'b0;
        R_VALID   = 1'b0;
        rsp_ready = 1'b0;
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic run_txn(input vec_t v);
        int  aw_w, w_w, b_w, ar_w, r_w, rs_w, cyc;
        bit  aw_d, w_d, b_d, ar_d, r_d, rsp_d, rsp_seen;
        int  n_aw, n_w, n_b, n_ar, n_r;
        aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0; rs_w = 0;
        aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; rsp_d = 0; rsp_seen = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        B_RESP = v.slv_resp;
        R_RESP = v.slv_resp;
        R_DATA = v.slv_rdata;

        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge A_CLK);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge A_CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0;
        cmd_addr  = 32'h0;
        cyc = 1;

        while (!rsp_d && cyc < 1000) begin
            AW_READY  = AW_VALID && (aw_w >= v.aw_lat);
            W_READY   = W_VALID && (w_w >= v.w_lat);
            B_VALID   = aw_d && w_d && !b_d && (b_w >= v.b_lat);
            AR_READY  = AR_VALID && (ar_w >= v.ar_lat);
            R_VALID   = ar_d && !r_d && (r_w >= v.r_lat);
            rsp_ready = rsp_valid && (rs_w >= v.rsp_lat);
            @(negedge A_CLK);
            // Response channels are sampled before the address flags update.
            if (aw_d && w_d && !b_d) begin
                if (B_VALID && B_READY) begin
                    b_d = 1;
                    n_b++;
                end else if (!B_VALID) b_w++;
            end
            if (ar_d && !r_d) begin
                if (R_VALID && R_READY) begin
                    r_d = 1;
                    n_r++;
                end else if (!R_VALID) r_w++;
            end
            if (AW_VALID) begin
                chk("aw_addr", AW_ADDR, v.addr);
                if (AW_READY) begin aw_d = 1; n_aw++; end else aw_w++;
            end
            if (W_VALID) begin
                chk("w_data", W_DATA, v.wdata);
                if (W_READY) begin w_d = 1; n_w++; end else w_w++;
            end
            if (AR_VALID) begin
                chk("ar_addr", AR_ADDR, v.addr);
                if (AR_READY) begin ar_d = 1; n_ar++; end else ar_w++;
            end
            if (rsp_valid) begin
                if (!rsp_seen && v.exp_cyc >= 0) chk("rsp_cycle", cyc, v.exp_cyc);
                rsp_seen = 1;
                chk("rsp_write", rsp_write, v.write);
                chk("rsp_rdata", rsp_rdata, v.exp_rdata);
                chk("rsp_resp", rsp_resp, v.exp_resp);
                chk("rsp_timeout", rsp_timeout, v.exp_to);
                chk("rsp_no_axi_valid", {AW_VALID, W_VALID, AR_VALID}, 3'b000);
                if (rsp_ready) rsp_d = 1; else rs_w++;
            end
            chk("cmd_ready_busy", cmd_ready, 1'b0);
            @(posedge A_CLK);
            #1;
            cyc++;
        end

        slave_idle();
        if (!rsp_d) begin
            n_vec++;
            n_err++;
            $display("FAIL txn_budget: no response within %0d cycles for addr %0h", cyc, v.addr);
        end
        chk("aw_count", n_aw, v.write ? 1 : 0);
        chk("w_count", n_w, v.write ? 1 : 0);
        chk("b_count", n_b, v.write ? 1 : 0);
        chk("ar_count", n_ar, v.write ? 0 : 1);
        chk("r_count", n_r, v.write ? 0 : 1);
        @(negedge A_CLK);
        chk("cmd_ready_after", cmd_ready, 1'b1);
        chk("state_after", dbg_state, IDLE);
        @(posedge A_CLK);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //          wr  addr          wdata         aw w  b    ar r  rsp resp   slv_rdata     exp_rdata     exp_resp to cyc
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 0, 0,   0, 0, 0,  OKAY,   32'hFFFF_0000, 32'h0,         OKAY,   1'b0, 3};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         0, 0, 0,   3, 3, 0,  EXOKAY, 32'h1234_5678, 32'h1234_5678, EXOKAY, 1'b0, 9};
        vecs[2] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 5, 0, 0,   0, 0, 0,  SLVERR, 32'h0,         32'h0,         SLVERR, 1'b0, 8};
        vecs[3] = '{1'b1, 32'h0000_0020, 32'h0BAD_C0DE, 0, 0, 300, 0, 0, 0,  OKAY,   32'h0,         32'h0,         OKAY,   1'b1, 303};
        vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,         0, 0, 0,   0, 0, 0,  DECERR, 32'hA5A5_0F0F, 32'hA5A5_0F0F, DECERR, 1'b0, 3};
        vecs[5] = '{1'b1, 32'h0000_0030, 32'h1357_9BDF, 0, 0, 0,   0, 0, 10, OKAY,   32'h0,         32'h0,         OKAY,   1'b0, 3};
        vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 0, 0,   1, 0, 10, OKAY,   32'h8000_0001, 32'h8000_0001, OKAY,   1'b0, 4};

        A_RSTn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        B_RESP    = 2'b00;
        R_RESP    = 2'b00;
        R_DATA    = 32'h0;
        slave_idle();

        #1;
        chk("rst_axi_ctl", {AW_VALID, W_VALID, B_READY, AR_VALID, R_READY}, 5'b0);
        chk("rst_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp}, 5'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_addr_data", {AW_ADDR, AR_ADDR, W_DATA}, 96'h0);
        chk("rst_state", dbg_state, IDLE);
        repeat (3) @(posedge A_CLK);
        @(negedge A_CLK);
        A_RSTn = 1'b1;
        @(posedge A_CLK);
        #1;

        // Stray responses while idle must not be accepted.
        B_VALID = 1'b1;
        R_VALID = 1'b1;
        @(negedge A_CLK);
        chk("idle_b_ready", B_READY, 1'b0);
        chk("idle_r_ready", R_READY, 1'b0);
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        @(posedge A_CLK);
        #1;
        slave_idle();

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
        end

        // Reset asserted while waiting for read data.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0040;
        AR_READY  = 1'b1;
        @(posedge A_CLK);
        #1;
        cmd_valid = 1'b0;
        @(negedge A_CLK);
        chk("mid_ar_valid", AR_VALID, 1'b1);
        @(posedge A_CLK);
        #1;
        AR_READY = 1'b0;
        @(negedge A_CLK);
        chk("mid_r_ready", R_READY, 1'b1);
        chk("mid_state", dbg_state, RD_RESP);
        #2;
        A_RSTn = 1'b0;
        #1;
        chk("mid_rst_outs", {AR_VALID, R_READY, rsp_valid}, 3'b000);
        chk("mid_rst_ar_addr", AR_ADDR, 32'h0);
        chk("mid_rst_state", dbg_state, IDLE);
        @(negedge A_CLK);
        A_RSTn = 1'b1;
        @(posedge A_CLK);
        #1;
        @(negedge A_CLK);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        @(posedge A_CLK);
        #1;

        // A normal write after the aborted read.
        run_txn(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
